// File: rtl/aes_keyram_ctrl_param.sv
// aes_keyram_ctrl_param
// ---------------------------------------------------------------------------
// Round-key RAM read controller. It fetches one round key as BEATS consecutive
// RAM words, assembles it in a shadow register and publishes it on
// key_round_rd with a one-cycle key_valid pulse. Round order is ascending
// (encrypt) or descending (decrypt). One extra request can be queued while a
// fetch is in flight. Overflow requests are dropped and flagged on key_err.
//
// Handshake: key_req is a single-cycle request pulse. Each accepted request
// produces exactly one key_valid pulse, in request order. A request is
// accepted when the controller is idle, or when it is busy and nothing is
// queued yet. Otherwise the request is dropped and key_err is set.
// key_round_rd, round_idx and key_last are meaningful while key_valid is high.
// key_round_rd and round_idx then hold until the next key_valid.
//
// Optional build macro:
//   KEYRAM_RDLAT2_EN - RAM read latency of 2 cycles (output-registered BRAM).
//                      When it is not defined the read latency is 1 cycle.
//
// Ports:
//   clk          clock
//   kill_n       asynchronous active-low reset
//   en_wr        key-expansion write enable; owns the RAM address, aborts fetch
//   addr_wr      key-expansion write address
//   key_start    pulse: latch dir, reload round pointer, abort any fetch
//   dir          0 = ascending rounds, 1 = descending rounds
//   key_req      pulse: request the next round key
//   ram_out      RAM read data
//   addr         RAM address (addr_wr while en_wr, else read address)
//   key_round_rd assembled round key
//   key_valid    one-cycle pulse: key_round_rd updated
//   key_last     final round of the sequence, with key_valid
//   round_idx    round index of key_round_rd
//   busy         fetch in progress
//   key_err      sticky request overflow, cleared by key_start
// ---------------------------------------------------------------------------
module aes_keyram_ctrl_param #(
  parameter int RAM_DW     = 64,
  parameter int KEY_W      = 128,
  parameter int NUM_ROUNDS = 11,
  parameter int ADDR_W     = 5,
  localparam int RIDX_W    = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1
) (
  input  logic              clk,
  input  logic              kill_n,
  input  logic              en_wr,
  input  logic [ADDR_W-1:0] addr_wr,
  input  logic              key_start,
  input  logic              dir,
  input  logic              key_req,
  input  logic [RAM_DW-1:0] ram_out,
  output logic [ADDR_W-1:0] addr,
  output logic [KEY_W-1:0]  key_round_rd,
  output logic              key_valid,
  output logic              key_last,
  output logic [RIDX_W-1:0] round_idx,
  output logic              busy,
  output logic              key_err
);

  // KEY_W must be an integer multiple of RAM_DW.
  localparam int BEATS  = KEY_W / RAM_DW;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
`ifdef KEYRAM_RDLAT2_EN
  localparam int RDLAT  = 2;
`else
  localparam int RDLAT  = 1;
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t             state, state_d;
  logic [BEAT_W-1:0]  beat;        // beat being addressed in ISSUE
  logic [BEAT_W-1:0]  cap_beat;    // beat whose data is on ram_out
  logic [RDLAT-1:0]   pipe;        // tracks issued beats through the RAM latency
  logic [KEY_W-1:0]   shadow;
  logic [KEY_W-1:0]   key_next;
  logic [RIDX_W-1:0]  ptr, ptr_step, start_ptr;
  logic               dir_r;
  logic               pending;
  logic [ADDR_W-1:0]  addr_rd;
  logic               abort, req_ok, cap_en, cap_last, issue_last;

  // en_wr owns the RAM port and swallows any request issued alongside it.
  assign abort      = en_wr | key_start;
  assign req_ok     = key_req & ~en_wr;
  assign cap_en     = pipe[RDLAT-1];
  assign cap_last   = (cap_beat == BEAT_W'(BEATS-1));
  assign issue_last = (beat == BEAT_W'(BEATS-1));

  assign addr_rd = ADDR_W'(32'(ptr) * BEATS + 32'(beat));
  assign addr    = en_wr ? addr_wr : addr_rd;

  assign busy      = (state != IDLE);
  // A DONE cycle means the key is already registered. An abort arriving in
  // that same cycle only affects what follows.
  assign key_valid = (state == DONE);
  assign key_last  = (state == DONE) &&
                     (dir_r ? (round_idx == '0)
                            : (round_idx == RIDX_W'(NUM_ROUNDS-1)));

  // Start value: key_start takes the new direction, other aborts keep dir_r.
  assign start_ptr = (key_start ? dir : dir_r) ? RIDX_W'(NUM_ROUNDS-1) : '0;

  always_comb begin
    ptr_step = ptr;
    if (dir_r) ptr_step = (ptr == '0) ? RIDX_W'(NUM_ROUNDS-1) : ptr - 1'b1;
    else       ptr_step = (ptr == RIDX_W'(NUM_ROUNDS-1)) ? '0 : ptr + 1'b1;
  end

  // Final beat goes straight from ram_out into the published key. A partial
  // key therefore never appears on key_round_rd.
  always_comb begin
    key_next = shadow;
    key_next[32'(cap_beat) * RAM_DW +: RAM_DW] = ram_out;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (req_ok) state_d = ISSUE;
      ISSUE:   if (issue_last) state_d = DRAIN;
      DRAIN:   if (cap_en && cap_last) state_d = DONE;
      DONE:    state_d = (pending || req_ok) ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
    // A start paired with a request restarts immediately on the new pointer.
    if (abort) state_d = (key_start && req_ok) ? ISSUE : IDLE;
  end

  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      state        <= IDLE;
      beat         <= '0;
      cap_beat     <= '0;
      pipe         <= '0;
      shadow       <= '0;
      key_round_rd <= '0;
      round_idx    <= '0;
      ptr          <= '0;
      dir_r        <= 1'b0;
      pending      <= 1'b0;
      key_err      <= 1'b0;
    end else begin
      state <= state_d;
      if (abort) begin
        // Flushing the capture pipe discards RAM data still in flight.
        beat     <= '0;
        cap_beat <= '0;
        pipe     <= '0;
        pending  <= 1'b0;
        ptr      <= start_ptr;
        if (key_start) begin
          dir_r   <= dir;
          key_err <= 1'b0;
        end
      end else begin
        pipe <= RDLAT'({pipe, state == ISSUE});
        if (state == ISSUE) beat <= issue_last ? '0 : beat + 1'b1;
        if (cap_en) begin
          shadow[32'(cap_beat) * RAM_DW +: RAM_DW] <= ram_out;
          if (cap_last) begin
            key_round_rd <= key_next;
            round_idx    <= ptr;
            cap_beat     <= '0;
          end else begin
            cap_beat <= cap_beat + 1'b1;
          end
        end
        case (state)
          ISSUE, DRAIN: begin
            if (req_ok) begin
              if (pending) key_err <= 1'b1;
              else         pending <= 1'b1;
            end
          end
          DONE: begin
            ptr <= ptr_step;
            // A queued request launches now. A fresh request in this cycle
            // either takes the free slot or, if one was queued, overflows.
            if (pending) begin
              pending <= 1'b0;
              if (req_ok) key_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_keyram_ctrl_param.sv
module tb_aes_keyram_ctrl_param;

  localparam int RAM_DW     = 64;
  localparam int KEY_W      = 128;
  localparam int NUM_ROUNDS = 11;
  localparam int ADDR_W     = 5;
  localparam int RIDX_W     = 4;
  localparam int BEATS      = KEY_W / RAM_DW;
`ifdef KEYRAM_RDLAT2_EN
  localparam int RDLAT = 2;
`else
  localparam int RDLAT = 1;
`endif
  // Request-to-key_valid distance for a fetch that starts immediately.
  localparam int LAT = BEATS + RDLAT + 1;

  // ---------------- clock / reset ----------------
  logic clk    = 1'b0;
  logic kill_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic              en_wr = 1'b0, key_start = 1'b0, dir = 1'b0, key_req = 1'b0;
  logic [ADDR_W-1:0] addr_wr = '0;
  logic [RAM_DW-1:0] ram_out;
  logic [ADDR_W-1:0] addr;
  logic [KEY_W-1:0]  key_round_rd;
  logic              key_valid, key_last, busy, key_err;
  logic [RIDX_W-1:0] round_idx;

  aes_keyram_ctrl_param #(
    .RAM_DW(RAM_DW), .KEY_W(KEY_W), .NUM_ROUNDS(NUM_ROUNDS), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .kill_n(kill_n), .en_wr(en_wr), .addr_wr(addr_wr),
    .key_start(key_start), .dir(dir), .key_req(key_req), .ram_out(ram_out),
    .addr(addr), .key_round_rd(key_round_rd), .key_valid(key_valid),
    .key_last(key_last), .round_idx(round_idx), .busy(busy), .key_err(key_err)
  );

  // ---------------- RAM model (address-tagged words) ----------------
  logic [RAM_DW-1:0] mem [0:31];
  logic [RAM_DW-1:0] rd1, rd2;
  always @(posedge clk) begin
    rd1 <= mem[addr];
    rd2 <= rd1;
  end
`ifdef KEYRAM_RDLAT2_EN
  assign ram_out = rd2;
`else
  assign ram_out = rd1;
`endif

  // ---------------- scoreboard ----------------
  typedef struct {
    int               cyc;
    logic [KEY_W-1:0] key;
    int               idx;
    logic             last;
  } exp_t;
  exp_t exp_q[$];

  int   checks = 0, passes = 0, fails = 0;
  logic mon_on = 1'b0;

  // Reference model: round pointer, direction, sticky error.
  int   ptr_m = 0;
  logic dir_m = 1'b0;
  logic err_m = 1'b0;

  task automatic check(input string nm, input logic [KEY_W-1:0] act, input logic [KEY_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h, required %h", nm, cyc, act, exp);
    end else begin
      passes++;
    end
  endtask

  // A request at cycle t counts the keys still due at or after t. With none
  // due, the key arrives LAT cycles later. With one due, it follows that key
  // by LAT. With two due, it is dropped.
  task automatic model_req(input int t);
    int   due;
    int   last_c;
    exp_t e;
    due = 0;
    last_c = -1;
    foreach (exp_q[i]) begin
      if (exp_q[i].cyc >= t) begin
        due++;
        if (exp_q[i].cyc > last_c) last_c = exp_q[i].cyc;
      end
    end
    if (due >= 2) begin
      err_m = 1'b1;
    end else begin
      e.cyc  = (due == 0) ? t + LAT : last_c + LAT;
      e.idx  = ptr_m;
      e.key  = {mem[2*ptr_m+1], mem[2*ptr_m]};
      e.last = dir_m ? (ptr_m == 0) : (ptr_m == NUM_ROUNDS-1);
      exp_q.push_back(e);
      if (dir_m) ptr_m = (ptr_m == 0) ? NUM_ROUNDS-1 : ptr_m - 1;
      else       ptr_m = (ptr_m == NUM_ROUNDS-1) ? 0 : ptr_m + 1;
    end
  endtask

  task automatic model_abort(input int t, input logic is_start, input logic d);
    while (exp_q.size() > 0 && exp_q[$].cyc > t) void'(exp_q.pop_back());
    if (is_start) begin
      dir_m = d;
      err_m = 1'b0;
    end
    ptr_m = dir_m ? NUM_ROUNDS-1 : 0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    ptr_m = 0;
    dir_m = 1'b0;
    err_m = 1'b0;
  endtask

  // Monitor: pops and compares on every key_valid and flags late keys.
  always @(negedge clk) begin
    exp_t e;
    if (mon_on) begin
      if (key_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_valid at cycle %0d: got key_valid=1, required 0", cyc);
        end else begin
          e = exp_q.pop_front();
          check("valid_cycle", KEY_W'(cyc), KEY_W'(e.cyc));
          check("key", key_round_rd, e.key);
          check("round_idx", KEY_W'(round_idx), KEY_W'(e.idx));
          check("key_last", KEY_W'(key_last), KEY_W'(e.last));
        end
      end else begin
        check("key_last_idle", KEY_W'(key_last), '0);
        if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          e = exp_q.pop_front();
          checks++;
          fails++;
          $display("FAIL missing_valid: key for round %0d got no key_valid, required at cycle %0d", e.idx, e.cyc);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic s, input logic d,
                       input logic [ADDR_W-1:0] wa);
    key_req = r; en_wr = w; key_start = s; dir = d; addr_wr = wa;
    if (w || s) model_abort(cyc, s, d);
    if (r && !w) model_req(cyc);
    step();
    key_req = 1'b0; en_wr = 1'b0; key_start = 1'b0;
  endtask

  task automatic req();
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic start(input logic d);
    drive(1'b0, 1'b0, 1'b1, d, '0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 60) begin
      step();
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL drain_timeout: %0d keys outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int a = 0; a < 32; a++) mem[a] = {32'hA500_0000 | 32'(a), $urandom()};
    #2 kill_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_key", key_round_rd, '0);
    check("rst_valid", KEY_W'(key_valid), '0);
    check("rst_last", KEY_W'(key_last), '0);
    check("rst_round_idx", KEY_W'(round_idx), '0);
    check("rst_busy", KEY_W'(busy), '0);
    check("rst_err", KEY_W'(key_err), '0);
    check("rst_addr", KEY_W'(addr), '0);
    kill_n = 1'b1;
    mon_on = 1'b1;
    step();

    // First key, ascending.
    start(1'b0);
    req();
    check("busy_after_req", KEY_W'(busy), 1);
    wait_idle();

    // Remaining ascending rounds plus the wrap back to round 0.
    for (int i = 0; i < NUM_ROUNDS + 1; i++) begin
      req();
      wait_idle();
    end

    // Descending sequence from the last round down to round 0.
    start(1'b1);
    for (int i = 0; i < NUM_ROUNDS; i++) begin
      req();
      wait_idle();
    end

    // Back-to-back requests: two delivered, third dropped.
    start(1'b0);
    req();
    req();
    req();
    wait_idle();
    check("err_after_overflow", KEY_W'(key_err), KEY_W'(err_m));
    check("err_set", KEY_W'(key_err), 1);
    start(1'b0);
    check("err_cleared", KEY_W'(key_err), 0);

    // Write-port abort mid-fetch.
    req();
    wait_idle();
    req();
    step();
    en_wr = 1'b1;
    addr_wr = 5'd7;
    model_abort(cyc, 1'b0, 1'b0);
    #1;
    check("addr_wr_mux", KEY_W'(addr), 7);
    step();
    en_wr = 1'b0;
    check("busy_after_abort", KEY_W'(busy), 0);
    repeat (6) step();
    req();
    wait_idle();

    // Asynchronous kill mid-fetch after a descending key is on the output.
    start(1'b1);
    req();
    wait_idle();
    req();
    step();
    @(negedge clk);
    kill_n = 1'b0;
    model_reset();
    #1;
    check("kill_key", key_round_rd, '0);
    check("kill_round_idx", KEY_W'(round_idx), '0);
    check("kill_busy", KEY_W'(busy), '0);
    check("kill_valid", KEY_W'(key_valid), '0);
    check("kill_addr", KEY_W'(addr), '0);
    step();
    kill_n = 1'b1;
    step();
    req();
    wait_idle();

    // Randomised traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      logic r, w, s, d, at_done;
      logic [ADDR_W-1:0] wa;
      at_done = 1'b0;
      foreach (exp_q[j]) if (exp_q[j].cyc == cyc) at_done = 1'b1;
      r  = ($urandom_range(0, 99) < 35);
      w  = !at_done && ($urandom_range(0, 99) < 3);
      s  = !at_done && ($urandom_range(0, 99) < 3);
      d  = 1'($urandom_range(0, 1));
      wa = ADDR_W'($urandom_range(0, 31));
      drive(r, w, s, d, wa);
    end
    wait_idle();
    check("err_random", KEY_W'(key_err), KEY_W'(err_m));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    checks++;
    fails++;
    $display("FAIL global_timeout: bench did not finish, required completion within budget");
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
